// File: rtl/cmn_clk_pkg.sv
// Shared types and helpers for the cmn clock-gating controller.
//   cmn_clk_state_e : controller FSM state encoding (also exported on state_o)
//   cnt_width()     : width of the shared idle/wake down-counter
package cmn_clk_pkg;

  typedef enum logic [1:0] {
    CLK_GATED = 2'd0,
    CLK_WAKE  = 2'd1,
    CLK_RUN   = 2'd2,
    CLK_IDLE  = 2'd3
  } cmn_clk_state_e;

  // Bits needed to hold max(idle, wake); never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned idle_c,
                                            input int unsigned wake_c);
    int unsigned m;
    m = (idle_c > wake_c) ? idle_c : wake_c;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cmn_clk_dn_cnt.sv
// Loadable down-counter that saturates at zero.
//   clk, rst    : clock, synchronous active-high reset (clears to 0)
//   load_i      : load load_val_i (takes priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one unless already zero
//   zero_o      : count is zero
module cmn_clk_dn_cnt #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cmn_clk_gate_ctrl.sv
// Clock-gating controller for one shared gated clock domain. Arbitrates
// NUM_REQ requesters, applies idle hysteresis before gating and a fixed
// wake latency before acknowledging.
//   clk, rst  : free-running source clock, synchronous active-high reset
//   req       : per-requester "need clock" level
//   force_on  : keep the clock running; wakes the domain if gated
//   clk_en    : registered enable to the external clock-gate cell
//   ack       : registered per-requester "clock running and stable"
//   gated     : registered, high while in CLK_GATED
//   state_o   : current FSM state
module cmn_clk_gate_ctrl
  import cmn_clk_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_on,
  output logic               clk_en,
  output logic [NUM_REQ-1:0] ack,
  output logic               gated,
  output logic [1:0]         state_o
);

  localparam int unsigned CW = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYCLES);
  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYCLES);

  cmn_clk_state_e     state_q;
  logic               clk_en_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               gated_q;

  logic               any_req;
  logic               cnt_load;
  logic [CW-1:0]      cnt_val;
  logic               cnt_dec;
  logic               cnt_zero;

  assign any_req = (|req) | force_on;

  // Counter control: one counter serves both the idle and the wake phase.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      CLK_RUN: begin
        if (!any_req) begin
          cnt_load = 1'b1;
          cnt_val  = IDLE_LD;
        end
      end
      CLK_IDLE: begin
        if (any_req) begin
          cnt_load = 1'b1;
          cnt_val  = '0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      CLK_GATED: begin
        if (any_req) begin
          cnt_load = 1'b1;
          cnt_val  = WAKE_LD;
        end
      end
      CLK_WAKE: cnt_dec = 1'b1;
      default: ;
    endcase
  end

  cmn_clk_dn_cnt #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Controller FSM; clk_en/ack/gated are all registered, so there is no
  // combinational path from req to the clock-gate enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLK_RUN;
      clk_en_q <= 1'b1;
      ack_q    <= '0;
      gated_q  <= 1'b0;
    end else begin
      case (state_q)
        CLK_RUN: begin
          clk_en_q <= 1'b1;
          if (!any_req) begin
            state_q <= CLK_IDLE;
            ack_q   <= '0;
          end else begin
            ack_q <= req;
          end
        end
        CLK_IDLE: begin
          // A request on the counter-zero edge wins over gating.
          if (any_req) begin
            state_q <= CLK_RUN;
          end else if (cnt_zero) begin
            state_q  <= CLK_GATED;
            clk_en_q <= 1'b0;
            gated_q  <= 1'b1;
          end
        end
        CLK_GATED: begin
          if (any_req) begin
            state_q  <= CLK_WAKE;
            clk_en_q <= 1'b1;
            gated_q  <= 1'b0;
          end
        end
        CLK_WAKE: begin
          // Never aborted, so the enable cannot glitch.
          if (cnt_zero) begin
            state_q <= CLK_RUN;
          end
        end
        default: begin
          state_q  <= CLK_RUN;
          clk_en_q <= 1'b1;
          ack_q    <= '0;
          gated_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clk_en  = clk_en_q;
  assign ack     = ack_q;
  assign gated   = gated_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cmn_clk_gate_ctrl.sv
// Self-checking bench for cmn_clk_gate_ctrl: default build (8/4) driven
// from a vector table plus hand sequences, and a 0/0 build for the
// zero-latency corners.
module tb_cmn_clk_gate_ctrl;
  import cmn_clk_pkg::*;

  typedef struct {
    bit             rst;
    logic [3:0]     req;
    bit             fo;
    bit             en;
    logic [3:0]     ack;
    bit             g;
    cmn_clk_state_e st;
  } vec_t;

  logic       clk;
  logic       rst_a, fo_a, en_a, g_a;
  logic [3:0] req_a, ack_a;
  logic [1:0] st_a;
  logic       rst_b, fo_b, en_b, g_b;
  logic [3:0] req_b, ack_b;
  logic [1:0] st_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step   = 0;

  vec_t vecs[$];
  vec_t sb[$];

  cmn_clk_gate_ctrl #(.NUM_REQ(4), .IDLE_CYCLES(8), .WAKE_CYCLES(4)) dut (
    .clk(clk), .rst(rst_a), .req(req_a), .force_on(fo_a),
    .clk_en(en_a), .ack(ack_a), .gated(g_a), .state_o(st_a)
  );

  cmn_clk_gate_ctrl #(.NUM_REQ(4), .IDLE_CYCLES(0), .WAKE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst_b), .req(req_b), .force_on(fo_b),
    .clk_en(en_b), .ack(ack_b), .gated(g_b), .state_o(st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input bit rst, input logic [3:0] req, input bit fo,
                              input bit en, input logic [3:0] ack, input bit g,
                              input cmn_clk_state_e st, input int n);
    vec_t v;
    v.rst = rst; v.req = req; v.fo = fo;
    v.en = en; v.ack = ack; v.g = g; v.st = st;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, n_step, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, push its expectation, then check after the edge.
  task automatic step(input bit sel, input vec_t v);
    vec_t e;
    if (!sel) begin
      rst_a = v.rst; req_a = v.req; fo_a = v.fo;
    end else begin
      rst_b = v.rst; req_b = v.req; fo_b = v.fo;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    n_step++;
    e = sb.pop_front();
    if (!sel) begin
      chk("clk_en",  32'(en_a), 32'(e.en));
      chk("ack",     32'(ack_a), 32'(e.ack));
      chk("gated",   32'(g_a), 32'(e.g));
      chk("state_o", 32'(st_a), 32'(e.st));
    end else begin
      chk("b_clk_en",  32'(en_b), 32'(e.en));
      chk("b_ack",     32'(ack_b), 32'(e.ack));
      chk("b_gated",   32'(g_b), 32'(e.g));
      chk("b_state_o", 32'(st_b), 32'(e.st));
    end
  endtask

  task automatic run(input bit sel, input bit rst, input logic [3:0] req, input bit fo,
                     input bit en, input logic [3:0] ack, input bit g,
                     input cmn_clk_state_e st, input int n);
    vec_t v;
    v.rst = rst; v.req = req; v.fo = fo;
    v.en = en; v.ack = ack; v.g = g; v.st = st;
    for (int i = 0; i < n; i++) step(sel, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; req_a = '0; fo_a = 1'b0;
    rst_b = 1'b1; req_b = '0; fo_b = 1'b0;

    // Reset, then idle with no requests: gate IDLE_CYCLES+1 edges later
    add(1, 4'b0000, 0, 1, 4'b0000, 0, CLK_RUN,   1);
    add(0, 4'b0000, 0, 1, 4'b0000, 0, CLK_IDLE,  9);
    add(0, 4'b0000, 0, 0, 4'b0000, 1, CLK_GATED, 2);
    // Wake on req[2]: ack at e+6
    add(0, 4'b0100, 0, 1, 4'b0000, 0, CLK_WAKE,  5);
    add(0, 4'b0100, 0, 1, 4'b0000, 0, CLK_RUN,   1);
    add(0, 4'b0100, 0, 1, 4'b0100, 0, CLK_RUN,   2);
    // Drop, re-raise req[0] three cycles later: no gating, no wake penalty
    add(0, 4'b0000, 0, 1, 4'b0000, 0, CLK_IDLE,  3);
    add(0, 4'b0001, 0, 1, 4'b0000, 0, CLK_RUN,   1);
    add(0, 4'b0001, 0, 1, 4'b0001, 0, CLK_RUN,   1);
    add(0, 4'b0101, 0, 1, 4'b0101, 0, CLK_RUN,   1);
    add(0, 4'b0100, 0, 1, 4'b0100, 0, CLK_RUN,   1);
    add(0, 4'b0011, 0, 1, 4'b0011, 0, CLK_RUN,   1);
    // Request on the counter-zero edge wins over gating
    add(0, 4'b0000, 0, 1, 4'b0000, 0, CLK_IDLE,  9);
    add(0, 4'b0010, 0, 1, 4'b0000, 0, CLK_RUN,   1);
    add(0, 4'b0010, 0, 1, 4'b0010, 0, CLK_RUN,   1);
    // Gate, then a one-cycle req[1] pulse: full wake, no ack, gate again
    add(0, 4'b0000, 0, 1, 4'b0000, 0, CLK_IDLE,  9);
    add(0, 4'b0000, 0, 0, 4'b0000, 1, CLK_GATED, 1);
    add(0, 4'b0010, 0, 1, 4'b0000, 0, CLK_WAKE,  1);
    add(0, 4'b0000, 0, 1, 4'b0000, 0, CLK_WAKE,  4);
    add(0, 4'b0000, 0, 1, 4'b0000, 0, CLK_RUN,   1);
    add(0, 4'b0000, 0, 1, 4'b0000, 0, CLK_IDLE,  9);
    add(0, 4'b0000, 0, 0, 4'b0000, 1, CLK_GATED, 1);
    // Reset during WAKE, then reset in RUN with ack high
    add(0, 4'b0001, 0, 1, 4'b0000, 0, CLK_WAKE,  2);
    add(1, 4'b0001, 0, 1, 4'b0000, 0, CLK_RUN,   1);
    add(0, 4'b0001, 0, 1, 4'b0001, 0, CLK_RUN,   1);
    add(0, 4'b1111, 0, 1, 4'b1111, 0, CLK_RUN,   1);
    add(1, 4'b1111, 0, 1, 4'b0000, 0, CLK_RUN,   1);
    // Reset during GATED
    add(0, 4'b0000, 0, 1, 4'b0000, 0, CLK_IDLE,  9);
    add(0, 4'b0000, 0, 0, 4'b0000, 1, CLK_GATED, 2);
    add(1, 4'b0000, 0, 1, 4'b0000, 0, CLK_RUN,   1);
    add(0, 4'b0000, 0, 1, 4'b0000, 0, CLK_IDLE,  9);
    add(0, 4'b0000, 0, 0, 4'b0000, 1, CLK_GATED, 1);

    foreach (vecs[i]) step(1'b0, vecs[i]);

    // force_on wakes the gated domain and holds it running without ack
    run(0, 0, 4'b0000, 1, 1, 4'b0000, 0, CLK_WAKE,  5);
    run(0, 0, 4'b0000, 1, 1, 4'b0000, 0, CLK_RUN,   100);
    run(0, 0, 4'b1000, 1, 1, 4'b1000, 0, CLK_RUN,   2);
    run(0, 0, 4'b0000, 0, 1, 4'b0000, 0, CLK_IDLE,  9);
    run(0, 0, 4'b0000, 0, 0, 4'b0000, 1, CLK_GATED, 2);

    // Zero-latency build
    run(1, 1, 4'b0000, 0, 1, 4'b0000, 0, CLK_RUN,   1);
    run(1, 0, 4'b0000, 0, 1, 4'b0000, 0, CLK_IDLE,  1);
    run(1, 0, 4'b0000, 0, 0, 4'b0000, 1, CLK_GATED, 2);
    run(1, 0, 4'b0001, 0, 1, 4'b0000, 0, CLK_WAKE,  1);
    run(1, 0, 4'b0001, 0, 1, 4'b0000, 0, CLK_RUN,   1);
    run(1, 0, 4'b0001, 0, 1, 4'b0001, 0, CLK_RUN,   1);
    run(1, 0, 4'b0000, 0, 1, 4'b0000, 0, CLK_IDLE,  1);
    run(1, 0, 4'b0100, 0, 1, 4'b0000, 0, CLK_RUN,   1);
    run(1, 0, 4'b0100, 0, 1, 4'b0100, 0, CLK_RUN,   1);
    run(1, 0, 4'b0000, 0, 1, 4'b0000, 0, CLK_IDLE,  1);
    run(1, 0, 4'b0000, 0, 0, 4'b0000, 1, CLK_GATED, 1);
    run(1, 1, 4'b0000, 0, 1, 4'b0000, 0, CLK_RUN,   1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
